// File: rtl/encode_pkg.sv
// Shared constants, FSM state encoding and helpers for the LZS output bit packer.
package encode_pkg;

  localparam int IN_WIDTH       = 13;
  localparam int NEED_STR_WIDTH = 4;
  localparam int OUT_WIDTH      = 64;
  localparam int LZF_WIDTH      = 20;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Whole bytes needed to hold `fill` stream bits (fill is at most 63).
  function automatic logic [3:0] bytes_of(input logic [6:0] fill);
    logic [6:0] t;
    t = fill + 7'd7;
    return t[6:3];
  endfunction

endpackage

// File: rtl/encode_out_merge.sv
// Combinational merge of one right-aligned code into the partial word, MSB-first,
// producing the completed word, the left-aligned spill and the new bit count.
module encode_out_merge
  import encode_pkg::*;
(
  input  logic [OUT_WIDTH-1:0]      acc,
  input  logic [6:0]                fill,
  input  logic [IN_WIDTH-1:0]       code,
  input  logic [NEED_STR_WIDTH-1:0] w,
  output logic [OUT_WIDTH-1:0]      merged,
  output logic [OUT_WIDTH-1:0]      spill,
  output logic [6:0]                sum
);

  localparam int WIN = OUT_WIDTH + IN_WIDTH;

  logic [IN_WIDTH-1:0] code_m;
  logic [WIN-1:0]      window;
  logic [6:0]          shamt;

  // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
  always_comb begin
    code_m = code & ~({IN_WIDTH{1'b1}} << w);
    sum    = fill + 7'(w);
    // Place the code directly below the bits already used; overflow lands in the low 13 bits.
    shamt  = 7'(WIN) - sum;
    window = {acc, {IN_WIDTH{1'b0}}} | ({{OUT_WIDTH{1'b0}}, code_m} << shamt);
    merged = window[WIN-1 -: OUT_WIDTH];
    spill  = {window[IN_WIDTH-1:0], {(OUT_WIDTH-IN_WIDTH){1'b0}}};
  end

endmodule

// File: rtl/encode_out.sv
// LZS encode output bit packer: packs 0..13-bit codes MSB-first into 64-bit FIFO words,
// closing the stream on flush with a byte-padded, last-marked word.
module encode_out #(
  parameter int IN_WIDTH       = encode_pkg::IN_WIDTH,
  parameter int NEED_STR_WIDTH = encode_pkg::NEED_STR_WIDTH,
  parameter int OUT_WIDTH      = encode_pkg::OUT_WIDTH,
  parameter int LZF_WIDTH      = encode_pkg::LZF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       code_data,
  input  logic [NEED_STR_WIDTH-1:0] code_width,
  input  logic                      code_valid,
  output logic                      code_ack,
  input  logic                      flush,
  output logic                      flush_done,
  input  logic                      fo_full,
  output logic [OUT_WIDTH-1:0]      fo_data,
  output logic                      fo_we,
  output logic                      out_last,
  output logic [3:0]                out_bytes,
  output logic [LZF_WIDTH-1:0]      fo_cnt
);

  import encode_pkg::*;

  state_t               state;
  logic [OUT_WIDTH-1:0] acc;
  logic [6:0]           fill;
  logic [OUT_WIDTH-1:0] merged;
  logic [OUT_WIDTH-1:0] spill;
  logic [6:0]           sum;
  logic                 completes;

  encode_out_merge u_merge (
    .acc    (acc),
    .fill   (fill),
    .code   (code_data),
    .w      (code_width),
    .merged (merged),
    .spill  (spill),
    .sum    (sum)
  );

  assign completes = (sum >= 7'd64);
  // fo_full only matters for the code that would complete a word.
  assign code_ack  = code_valid && (state == S_RUN) && (!completes || !fo_full);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_RUN;
      acc        <= '0;
      fill       <= '0;
      fo_data    <= '0;
      fo_we      <= 1'b0;
      out_last   <= 1'b0;
      out_bytes  <= '0;
      fo_cnt     <= '0;
      flush_done <= 1'b0;
    end else begin
      fo_we      <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        S_RUN: begin
          if (code_ack) begin
            if (completes) begin
              fo_data   <= merged;
              fo_we     <= 1'b1;
              out_bytes <= 4'd8;
              out_last  <= 1'b0;
              fo_cnt    <= fo_cnt + 1'b1;
              acc       <= spill;
              fill      <= sum - 7'd64;
            end else begin
              acc  <= merged;
              fill <= sum;
            end
          end else if (flush && !code_valid) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!fo_full) begin
            fo_data    <= acc;
            fo_we      <= 1'b1;
            out_bytes  <= bytes_of(fill);
            out_last   <= 1'b1;
            fo_cnt     <= fo_cnt + 1'b1;
            acc        <= '0;
            fill       <= '0;
            flush_done <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (!flush) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
